// File: rtl/dot_prod_argmax_pkg.sv
// Shared definitions for the CAF peak-search stage: state encoding, default
// datapath widths shared with the dot-product stage, and a width helper.
package dot_prod_argmax_pkg;

  localparam int unsigned DEF_I_BITS = 24;
  localparam int unsigned DEF_Q_BITS = 24;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/dot_prod_argmax_cpx_mag.sv
// Registered complex magnitude squared (i*i + q*q) with one-cycle latency;
// valid and sample index travel alongside as sideband.
module cpx_mag_sq #(
  parameter int i_bits     = 24,
  parameter int q_bits     = 24,
  parameter int mag_bits   = 48,
  parameter int index_bits = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid,
  input  logic signed [i_bits-1:0]     i,
  input  logic signed [q_bits-1:0]     q,
  input  logic        [index_bits-1:0] index,
  output logic                         mag_valid,
  output logic        [mag_bits-1:0]   mag,
  output logic        [index_bits-1:0] mag_index
);

  localparam int SQ_I = 2 * i_bits;
  localparam int SQ_Q = 2 * q_bits;

  // Operands are sign-extended to full product width so the most-negative
  // input squares exactly; the non-negative result then zero-extends safely.
  logic signed [SQ_I-1:0] i_ext, i_sq;
  logic signed [SQ_Q-1:0] q_ext, q_sq;
  logic        [mag_bits-1:0] mag_next;

  always_comb begin
    i_ext    = SQ_I'(i);
    q_ext    = SQ_Q'(q);
    i_sq     = i_ext * i_ext;
    q_sq     = q_ext * q_ext;
    mag_next = mag_bits'($unsigned(i_sq)) + mag_bits'($unsigned(q_sq));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_valid <= 1'b0;
      mag       <= '0;
      mag_index <= '0;
    end else begin
      mag_valid <= valid;
      if (valid) begin
        mag       <= mag_next;
        mag_index <= index;
      end
    end
  end

endmodule

// File: rtl/dot_prod_argmax.sv
// Peak search over a window of complex dot-product results: tracks the largest
// magnitude squared and its index, then offers them on a valid/ready output.
module dot_prod_argmax
  import dot_prod_argmax_pkg::*;
#(
  parameter int i_bits     = DEF_I_BITS,
  parameter int q_bits     = DEF_Q_BITS,
  parameter int length     = 16,
  parameter int index_bits = 4,
  parameter int mag_bits   = 48
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         m_axis_product_tvalid,
  input  logic signed [i_bits-1:0]     i,
  input  logic signed [q_bits-1:0]     q,
  output logic                         m_axis_product_tready,
  input  logic                         m_axis_peak_tready,
  output logic                         s_axis_peak_tvalid,
  output logic        [mag_bits-1:0]   peak_mag,
  output logic        [index_bits-1:0] peak_index
);

  if (index_bits < int'(clog2(length))) begin : g_bad_index_bits
    $error("index_bits too small for length");
  end

  localparam logic [index_bits-1:0] LAST = index_bits'(length - 1);
  localparam logic [index_bits-1:0] ONE  = index_bits'(1);

  state_t                     state;
  logic [index_bits-1:0]      cnt;
  logic                       accept;

  logic                       v1;
  logic signed [i_bits-1:0]   i1;
  logic signed [q_bits-1:0]   q1;
  logic [index_bits-1:0]      idx1;

  logic                       mag_valid;
  logic [mag_bits-1:0]        mag;
  logic [index_bits-1:0]      mag_index;

  logic [mag_bits-1:0]        best_mag, best_mag_next;
  logic [index_bits-1:0]      best_index, best_index_next;
  logic                       take;

  assign m_axis_product_tready = (state == ACCUM);
  assign accept = m_axis_product_tvalid & m_axis_product_tready;

  cpx_mag_sq #(
    .i_bits    (i_bits),
    .q_bits    (q_bits),
    .mag_bits  (mag_bits),
    .index_bits(index_bits)
  ) u_mag (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (v1),
    .i        (i1),
    .q        (q1),
    .index    (idx1),
    .mag_valid(mag_valid),
    .mag      (mag),
    .mag_index(mag_index)
  );

  // Index 0 opens a new window; strict compare keeps the earliest on ties.
  always_comb begin
    take            = mag_valid && ((mag_index == '0) || (mag > best_mag));
    best_mag_next   = take ? mag : best_mag;
    best_index_next = take ? mag_index : best_index;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ACCUM;
      cnt                <= '0;
      v1                 <= 1'b0;
      i1                 <= '0;
      q1                 <= '0;
      idx1               <= '0;
      best_mag           <= '0;
      best_index         <= '0;
      s_axis_peak_tvalid <= 1'b0;
      peak_mag           <= '0;
      peak_index         <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        i1   <= i;
        q1   <= q;
        idx1 <= cnt;
        cnt  <= (cnt == LAST) ? '0 : cnt + ONE;
      end
      best_mag   <= best_mag_next;
      best_index <= best_index_next;

      case (state)
        ACCUM: if (accept && (cnt == LAST)) state <= DRAIN;
        // Publish the combinational next-best so the final sample's own
        // compare is included on the same edge.
        DRAIN: if (mag_valid && (mag_index == LAST)) begin
          peak_mag           <= best_mag_next;
          peak_index         <= best_index_next;
          s_axis_peak_tvalid <= 1'b1;
          state              <= DONE;
        end
        DONE: if (m_axis_peak_tready) begin
          s_axis_peak_tvalid <= 1'b0;
          state              <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_prod_argmax.sv
// Directed self-checking bench for dot_prod_argmax with a 4-sample window.
module tb_dot_prod_argmax;

  localparam int LEN = 4;
  localparam int IB  = 2;
  localparam int MB  = 48;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 m_axis_product_tvalid;
  logic signed [23:0]   i, q;
  logic                 m_axis_product_tready;
  logic                 m_axis_peak_tready;
  logic                 s_axis_peak_tvalid;
  logic [MB-1:0]        peak_mag;
  logic [IB-1:0]        peak_index;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dot_prod_argmax #(
    .i_bits    (24),
    .q_bits    (24),
    .length    (LEN),
    .index_bits(IB),
    .mag_bits  (MB)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .m_axis_product_tvalid(m_axis_product_tvalid),
    .i                    (i),
    .q                    (q),
    .m_axis_product_tready(m_axis_product_tready),
    .m_axis_peak_tready   (m_axis_peak_tready),
    .s_axis_peak_tvalid   (s_axis_peak_tvalid),
    .peak_mag             (peak_mag),
    .peak_index           (peak_index)
  );

  // Present one sample and let the next rising edge take it.
  task automatic send(input logic signed [23:0] a, input logic signed [23:0] b);
    @(negedge clk);
    m_axis_product_tvalid = 1'b1;
    i = a;
    q = b;
    @(posedge clk);
    #1;
    m_axis_product_tvalid = 1'b0;
  endtask

  // Edges from the last accept until peak valid; bounded at 20.
  task automatic wait_valid(output int cycles, output logic rdy_seen);
    cycles   = 0;
    rdy_seen = m_axis_product_tready;
    while (!s_axis_peak_tvalid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
      rdy_seen = rdy_seen | m_axis_product_tready;
    end
  endtask

  task automatic do_handshake;
    @(negedge clk);
    m_axis_peak_tready = 1'b1;
    @(posedge clk);
    #1;
    m_axis_peak_tready    = 1'b0;
    m_axis_product_tvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m_axis_product_tvalid = ~m_axis_product_tvalid;
      i = 24'sd1000 + 24'(k);
      q = -24'sd77;
    end
    checks++; if (s_axis_peak_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b want 0", s_axis_peak_tvalid); end
    checks++; if (peak_mag !== '0) begin errors++; $display("FAIL reset_mag got %0d want 0", peak_mag); end
    checks++; if (peak_index !== '0) begin errors++; $display("FAIL reset_index got %0d want 0", peak_index); end
    checks++; if (m_axis_product_tready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", m_axis_product_tready); end
    @(posedge clk);
    #3;
    m_axis_product_tvalid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (m_axis_product_tready !== 1'b1) begin errors++; $display("FAIL release_ready got %0b want 1", m_axis_product_tready); end
    @(negedge clk);
    checks++; if (s_axis_peak_tvalid !== 1'b0) begin errors++; $display("FAIL release_tvalid got %0b want 0", s_axis_peak_tvalid); end
    checks++; if (peak_mag !== '0) begin errors++; $display("FAIL release_mag got %0d want 0", peak_mag); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic rdy;
    send(24'sd3, 24'sd4);
    send(-24'sd5, 24'sd0);
    send(24'sd1, 24'sd1);
    send(24'sd0, -24'sd2);
    wait_valid(cyc, rdy);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL b2b_latency got %0d want 2", cyc); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_ready_low got %0b want 0", rdy); end
    checks++; if (peak_mag !== 48'd25) begin errors++; $display("FAIL b2b_mag got %0d want 25", peak_mag); end
    checks++; if (peak_index !== 2'd0) begin errors++; $display("FAIL b2b_index got %0d want 0", peak_index); end
    do_handshake();
    checks++; if (s_axis_peak_tvalid !== 1'b0) begin errors++; $display("FAIL b2b_tvalid_drop got %0b want 0", s_axis_peak_tvalid); end
    checks++; if (peak_mag !== 48'd25) begin errors++; $display("FAIL b2b_mag_hold got %0d want 25", peak_mag); end
  endtask

  task automatic test_extremes;
    int cyc;
    logic rdy;
    send(24'sd0, 24'sd0);
    send(24'sd0, 24'sd0);
    send(-24'sd8388608, -24'sd8388608);
    send(24'sd8388607, 24'sd0);
    wait_valid(cyc, rdy);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL ext_latency got %0d want 2", cyc); end
    checks++; if (peak_mag !== 48'h8000_0000_0000) begin errors++; $display("FAIL ext_mag got %0h want 800000000000", peak_mag); end
    checks++; if (peak_index !== 2'd2) begin errors++; $display("FAIL ext_index got %0d want 2", peak_index); end
    do_handshake();
  endtask

  task automatic test_backpressure;
    int cyc;
    logic rdy;
    send(24'sd7, 24'sd0);
    send(24'sd0, -24'sd8);
    send(24'sd8, 24'sd1);
    send(-24'sd3, -24'sd3);
    wait_valid(cyc, rdy);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL bp_latency got %0d want 2", cyc); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      m_axis_product_tvalid = 1'b1;
      i = 24'sd100;
      q = 24'sd100;
      checks++; if (s_axis_peak_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid[%0d] got %0b want 1", k, s_axis_peak_tvalid); end
      checks++; if (peak_mag !== 48'd65) begin errors++; $display("FAIL bp_mag[%0d] got %0d want 65", k, peak_mag); end
      checks++; if (peak_index !== 2'd2) begin errors++; $display("FAIL bp_index[%0d] got %0d want 2", k, peak_index); end
      checks++; if (m_axis_product_tready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %0b want 0", k, m_axis_product_tready); end
    end
    do_handshake();
    checks++; if (s_axis_peak_tvalid !== 1'b0) begin errors++; $display("FAIL bp_tvalid_drop got %0b want 0", s_axis_peak_tvalid); end
    checks++; if (m_axis_product_tready !== 1'b1) begin errors++; $display("FAIL bp_ready_return got %0b want 1", m_axis_product_tready); end
  endtask

  task automatic test_gapped;
    int cyc;
    logic rdy;
    send(24'sd3, 24'sd4);
    @(posedge clk); #1;
    send(-24'sd5, 24'sd0);
    @(posedge clk); #1;
    send(24'sd1, 24'sd1);
    @(posedge clk); #1;
    send(24'sd0, -24'sd2);
    wait_valid(cyc, rdy);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL gap_latency got %0d want 2", cyc); end
    checks++; if (peak_mag !== 48'd25) begin errors++; $display("FAIL gap_mag got %0d want 25", peak_mag); end
    checks++; if (peak_index !== 2'd0) begin errors++; $display("FAIL gap_index got %0d want 0", peak_index); end
    do_handshake();
  endtask

  task automatic test_reset_mid_window;
    int cyc;
    logic rdy;
    send(24'sd50, 24'sd50);
    send(24'sd60, 24'sd60);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (peak_mag !== '0) begin errors++; $display("FAIL mid_rst_mag got %0d want 0", peak_mag); end
    checks++; if (m_axis_product_tready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %0b want 1", m_axis_product_tready); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    send(24'sd1, 24'sd0);
    send(24'sd0, 24'sd3);
    send(24'sd2, 24'sd2);
    send(24'sd0, 24'sd0);
    wait_valid(cyc, rdy);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL fresh_latency got %0d want 2", cyc); end
    checks++; if (peak_mag !== 48'd9) begin errors++; $display("FAIL fresh_mag got %0d want 9", peak_mag); end
    checks++; if (peak_index !== 2'd1) begin errors++; $display("FAIL fresh_index got %0d want 1", peak_index); end
    do_handshake();
  endtask

  initial begin
    rst_n                 = 1'b0;
    m_axis_product_tvalid = 1'b0;
    m_axis_peak_tready    = 1'b0;
    i                     = '0;
    q                     = '0;
    test_reset();
    test_back_to_back();
    test_extremes();
    test_backpressure();
    test_gapped();
    test_reset_mid_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
